data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters.
- Port A is the pipeline MEM stage (load/store); port B is a secondary master (test loader / debug DMA).
- Sequences each multi-cycle access: issue, fixed-latency wait, one-cycle completion pulse.
- Produces the pipeline stall while port A waits. Sits between the MEM stage and the data memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the issue cycle to valid read data; legal range 1..15.
- STARVE_MAX, 4, consecutive A grants with B pending before B is forced; legal range 1..15.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- A_Req  in  1  port A request; held until A_Ready.
- A_Write  in  1  1 = store, 0 = load.
- A_Addr  in  ADDR_W  port A byte address.
- A_WData  in  DATA_W  port A store data.
- A_Ready  out  1  one-cycle completion pulse to port A.
- A_RData  out  DATA_W  port A load data; valid with A_Ready and held until the next A completion.
- B_Req, B_Write, B_Addr, B_WData, B_Ready, B_RData: same as the A group, for port B.
- Mem_Addr  out  ADDR_W  memory address.
- Mem_WData  out  DATA_W  memory write data.
- Mem_Read  out  1  memory read strobe.
- Mem_Write  out  1  memory write strobe.
- Mem_RData  in  DATA_W  memory read data.
- Stall_Pipe  out  1  combinational: A_Req & ~A_Ready.
- Grant_B  out  1  current or most recent owner is B (observability).

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- Reset values: all outputs 0, latency counter 0, starvation counter 0. Reset is asynchronous, so it takes effect mid-access: strobes drop immediately and no Ready pulse is produced.
- IDLE: sample requests. Grant decision:
  - A only: grant A.
  - B only: grant B.
  - Both: grant B if starve_cnt == STARVE_MAX, otherwise grant A.
  - Neither: stay in IDLE.
- On any grant: latch Write/Addr/WData into registers, set the owner, go to ISSUE.
- ISSUE: exactly one cycle. Mem_Read = ~wr, Mem_Write = wr. Mem_Addr/Mem_WData come from the latched registers. Load the counter with MEM_LAT-1, then go to WAIT (or DONE if MEM_LAT == 1).
- WAIT: strobes low; Mem_Addr still held. Decrement the counter; go to DONE when it reaches 0.
- DONE: capture Mem_RData into the owner's RData register on a load (a store leaves RData unchanged). Pulse the owner's Ready for exactly this cycle. Return to IDLE.
- Latency: request seen in IDLE at cycle N, so Ready and RData arrive at cycle N+1+MEM_LAT.
  - Throughput: one access per MEM_LAT+2 cycles.
  - The earliest re-grant is the IDLE cycle after DONE.
- Starvation counter:
  - Increments on an A grant while B_Req = 1, saturating at STARVE_MAX.
  - Clears on any B grant, or on an A grant while B_Req = 0.
- Requests and inputs are sampled only in IDLE. Changes to Addr/WData/Write during an access are ignored.
- If a requester deasserts Req mid-access, the access still completes and Ready still pulses; the requester ignores it.
- The non-owner's Ready stays 0 throughout.
- Mem_Addr/Mem_WData are held at their last values while in IDLE; there is no glitch to 0.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, priority goes to the port not granted last; reset favours A. The starvation counter is removed. Grant_B still reflects the owner.
- Undefined: fixed A priority with the STARVE_MAX starvation guard, as described under Behaviour.

Test Plan:
- Load A at 0x10 (mem holds 0xDEADBEEF), MEM_LAT=2, req at cycle 0: Mem_Read=1 at cycle 1 only, A_Ready=1 at cycle 3, A_RData=0xDEADBEEF, Stall_Pipe=1 for cycles 0-2.
- Store B 0x0000_1234 to 0x20: Mem_Write=1 for one cycle with Mem_Addr=0x20; B_Ready at cycle 3; a later A load from 0x20 returns 0x1234.
- A and B held continuously, STARVE_MAX=4: grant sequence A,A,A,A,B,A,A,A,A,B; B_Ready every 5th completion.
- Rst asserted in the WAIT cycle of an A load: Mem_Read, A_Ready and Stall-related state clear in the same cycle; after release, a new A load completes normally and no stale Ready appears.
- A drops A_Req in WAIT: A_Ready still pulses in DONE; the arbiter returns to IDLE and a pending B is granted the next cycle.
- With ARB_ROUND_ROBIN_EN, both ports held: grants alternate A,B,A,B; the first grant after reset is A.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Arbiter sharing one single-port data memory between the MEM stage (A) and a secondary master (B).
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating priority instead of A priority with a starvation guard.
module data_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              A_Req,
  input  logic              A_Write,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [DATA_W-1:0] A_WData,
  output logic              A_Ready,
  output logic [DATA_W-1:0] A_RData,
  input  logic              B_Req,
  input  logic              B_Write,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [DATA_W-1:0] B_WData,
  output logic              B_Ready,
  output logic [DATA_W-1:0] B_RData,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  output logic              Mem_Read,
  output logic              Mem_Write,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Stall_Pipe,
  output logic              Grant_B,
  output logic [1:0]        Dbg_State
);

  // Handshake: a port raises Req with Write/Addr/WData stable and holds it until its
  // Ready pulses for one cycle; request fields are only sampled while the arbiter is idle.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic              own_b_q, own_b_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              grant_b;
  logic              done_load;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_b_q, prio_b_d;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q, starve_d;
`endif

  always_comb begin
    state_d   = state_q;
    own_b_d   = own_b_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    grant_b   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    prio_b_d  = prio_b_q;
`else
    starve_d  = starve_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_b = B_Req & (~A_Req | prio_b_q);
`else
        grant_b = B_Req & (~A_Req | (starve_q == STARVE_LIM));
`endif
        if (A_Req | B_Req) begin
          state_d = S_ISSUE;
          own_b_d = grant_b;
          wr_d    = grant_b ? B_Write : A_Write;
          addr_d  = grant_b ? B_Addr  : A_Addr;
          wdata_d = grant_b ? B_WData : A_WData;
`ifdef ARB_ROUND_ROBIN_EN
          prio_b_d = ~grant_b;
`else
          if (grant_b || !B_Req)          starve_d = 4'd0;
          else if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = (MEM_LAT == 1) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!wr_q) begin
          if (own_b_q) b_rdata_d = Mem_RData;
          else         a_rdata_d = Mem_RData;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      own_b_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_b_q  <= 1'b0;
`else
      starve_q  <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      own_b_q   <= own_b_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      prio_b_q  <= prio_b_d;
`else
      starve_q  <= starve_d;
`endif
    end
  end

  // Load data is forwarded in the completion cycle so RData is valid alongside Ready.
  assign done_load  = (state_q == S_DONE) & ~wr_q;
  assign A_Ready    = (state_q == S_DONE) & ~own_b_q;
  assign B_Ready    = (state_q == S_DONE) &  own_b_q;
  assign A_RData    = (done_load & ~own_b_q) ? Mem_RData : a_rdata_q;
  assign B_RData    = (done_load &  own_b_q) ? Mem_RData : b_rdata_q;
  assign Mem_Addr   = addr_q;
  assign Mem_WData  = wdata_q;
  assign Mem_Read   = (state_q == S_ISSUE) & ~wr_q;
  assign Mem_Write  = (state_q == S_ISSUE) &  wr_q;
  assign Stall_Pipe = A_Req & ~A_Ready;
  assign Grant_B    = own_b_q;
  assign Dbg_State  = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: transaction-level model compared every cycle plus directed checks.
module tb_data_mem_arbiter;

  localparam int L    = 2;
  localparam int SMAX = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        A_Req = 0, A_Write = 0, B_Req = 0, B_Write = 0;
  logic [31:0] A_Addr = 0, A_WData = 0, B_Addr = 0, B_WData = 0;
  logic        A_Ready, B_Ready, Mem_Read, Mem_Write, Stall_Pipe, Grant_B;
  logic [31:0] A_RData, B_RData, Mem_Addr, Mem_WData;
  logic [31:0] Mem_RData = 32'hBAD0_BAD0;
  logic [1:0]  Dbg_State;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
    .Clk(Clk), .Rst(Rst),
    .A_Req(A_Req), .A_Write(A_Write), .A_Addr(A_Addr), .A_WData(A_WData),
    .A_Ready(A_Ready), .A_RData(A_RData),
    .B_Req(B_Req), .B_Write(B_Write), .B_Addr(B_Addr), .B_WData(B_WData),
    .B_Ready(B_Ready), .B_RData(B_RData),
    .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_RData(Mem_RData), .Stall_Pipe(Stall_Pipe), .Grant_B(Grant_B), .Dbg_State(Dbg_State)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: read data is only valid exactly L cycles after the read strobe cycle
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  int          rd_cnt = 0;
  logic [31:0] rd_addr = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge Clk) begin
    Mem_RData <= 32'hBAD0_BAD0;
    if (Rst) begin
      rd_cnt <= 0;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt <= rd_cnt - 1;
        if (rd_cnt == 1) Mem_RData <= mem_rd(rd_addr);
      end
      if (Mem_Read) begin
        if (L == 1) Mem_RData <= mem_rd(Mem_Addr);
        else begin
          rd_cnt  <= L - 1;
          rd_addr <= Mem_Addr;
        end
      end
      if (Mem_Write) mem[Mem_Addr] = Mem_WData;
    end
  end

  // transaction model: k counts cycles into the current access (0 = idle)
  int          k = 0;
  int          m_starve = 0;
  logic        m_prio_b = 0, m_own_b = 0, m_wr = 0, gb;
  logic [31:0] m_addr = 0, m_wdata = 0, m_a_rdata = 0, m_b_rdata = 0, m_load_val = 0;

  always @(posedge Clk) begin
    if (Rst) begin
      k = 0; m_starve = 0; m_prio_b = 0; m_own_b = 0; m_wr = 0;
      m_addr = 0; m_wdata = 0; m_a_rdata = 0; m_b_rdata = 0;
    end else if (k == 0) begin
      if (A_Req || B_Req) begin
`ifdef ARB_ROUND_ROBIN_EN
        gb = B_Req && (!A_Req || m_prio_b);
`else
        gb = B_Req && (!A_Req || m_starve == SMAX);
`endif
        m_starve = (gb || !B_Req) ? 0 : ((m_starve < SMAX) ? m_starve + 1 : SMAX);
        m_prio_b = !gb;
        m_own_b  = gb;
        m_wr     = gb ? B_Write : A_Write;
        m_addr   = gb ? B_Addr  : A_Addr;
        m_wdata  = gb ? B_WData : A_WData;
        if (m_wr) exp_mem[m_addr] = m_wdata;
        else m_load_val = exp_mem.exists(m_addr) ? exp_mem[m_addr] : 32'h0;
        k = 1;
      end
    end else if (k == L + 1) begin
      if (!m_wr) begin
        if (m_own_b) m_b_rdata = m_load_val;
        else         m_a_rdata = m_load_val;
      end
      k = 0;
    end else begin
      k++;
    end
  end

  // scoreboard compare, every cycle outside reset
  always @(negedge Clk) begin
    logic done, ea, eb;
    if (!Rst) begin
      done = (k == L + 1);
      ea   = done && !m_own_b;
      eb   = done &&  m_own_b;
      check("m_mem_read",  32'(Mem_Read),  32'(k == 1 && !m_wr));
      check("m_mem_write", 32'(Mem_Write), 32'(k == 1 &&  m_wr));
      check("m_mem_addr",  Mem_Addr,  m_addr);
      check("m_mem_wdata", Mem_WData, m_wdata);
      check("m_a_ready",   32'(A_Ready), 32'(ea));
      check("m_b_ready",   32'(B_Ready), 32'(eb));
      check("m_a_rdata",   A_RData, (ea && !m_wr) ? m_load_val : m_a_rdata);
      check("m_b_rdata",   B_RData, (eb && !m_wr) ? m_load_val : m_b_rdata);
      check("m_stall",     32'(Stall_Pipe), 32'(A_Req && !ea));
      check("m_grant_b",   32'(Grant_B), 32'(m_own_b));
    end
  end

  // drivers
  task automatic do_reset();
    @(posedge Clk); #1 Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  task automatic a_load(input logic [31:0] addr, output logic [31:0] rd, output int lat);
    bit found;
    @(posedge Clk); #1;
    A_Req = 1; A_Write = 0; A_Addr = addr;
    lat = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      if (A_Ready) found = 1;
      else lat++;
    end
    check("a_load_timeout", 32'(found), 32'd1);
    rd = A_RData;
    @(posedge Clk); #1 A_Req = 0;
  endtask

  task automatic wait_b_ready(output logic [31:0] rd);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      if (B_Ready) found = 1;
    end
    check("b_timeout", 32'(found), 32'd1);
    rd = B_RData;
  endtask

  logic [31:0] rd;
  int          lat;
  logic [9:0]  exp_seq;
  bit          got;

  initial begin
    mem[32'h10] = 32'hDEAD_BEEF; exp_mem[32'h10] = 32'hDEAD_BEEF;
    mem[32'h30] = 32'hCAFE_F00D; exp_mem[32'h30] = 32'hCAFE_F00D;

    // reset values
    repeat (2) @(negedge Clk);
    check("rst_mem_read", 32'(Mem_Read), 32'd0);
    check("rst_mem_write", 32'(Mem_Write), 32'd0);
    check("rst_a_ready", 32'(A_Ready), 32'd0);
    check("rst_grant_b", 32'(Grant_B), 32'd0);
    check("rst_mem_addr", Mem_Addr, 32'd0);
    check("rst_a_rdata", A_RData, 32'd0);
    @(posedge Clk); #1 Rst = 1'b0;

    // A load 0x10, requested in cycle 0
    @(posedge Clk); #1;
    A_Req = 1; A_Write = 0; A_Addr = 32'h10;
    @(negedge Clk);
    check("t1_c0_stall", 32'(Stall_Pipe), 32'd1);
    check("t1_c0_read", 32'(Mem_Read), 32'd0);
    @(negedge Clk);
    check("t1_c1_read", 32'(Mem_Read), 32'd1);
    check("t1_c1_addr", Mem_Addr, 32'h10);
    @(negedge Clk);
    check("t1_c2_read", 32'(Mem_Read), 32'd0);
    check("t1_c2_stall", 32'(Stall_Pipe), 32'd1);
    @(negedge Clk);
    check("t1_c3_ready", 32'(A_Ready), 32'd1);
    check("t1_c3_rdata", A_RData, 32'hDEAD_BEEF);
    check("t1_c3_stall", 32'(Stall_Pipe), 32'd0);
    @(posedge Clk); #1 A_Req = 0;
    @(negedge Clk);
    check("t1_c4_ready", 32'(A_Ready), 32'd0);
    check("t1_c4_rdata_hold", A_RData, 32'hDEAD_BEEF);

    // B store 0x1234 to 0x20, then A reads it back
    @(posedge Clk); #1;
    B_Req = 1; B_Write = 1; B_Addr = 32'h20; B_WData = 32'h0000_1234;
    @(negedge Clk);
    @(negedge Clk);
    check("t2_c1_write", 32'(Mem_Write), 32'd1);
    check("t2_c1_read", 32'(Mem_Read), 32'd0);
    check("t2_c1_addr", Mem_Addr, 32'h20);
    check("t2_c1_wdata", Mem_WData, 32'h0000_1234);
    @(negedge Clk);
    check("t2_c2_write", 32'(Mem_Write), 32'd0);
    @(negedge Clk);
    check("t2_c3_b_ready", 32'(B_Ready), 32'd1);
    check("t2_c3_a_ready", 32'(A_Ready), 32'd0);
    check("t2_c3_grant_b", 32'(Grant_B), 32'd1);
    check("t2_a_rdata_hold", A_RData, 32'hDEAD_BEEF);
    @(posedge Clk); #1 B_Req = 0; B_Write = 0;
    a_load(32'h20, rd, lat);
    check("t2_readback", rd, 32'h0000_1234);

    // both ports held continuously
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = 10'b10_1010_1010;
`else
    exp_seq = 10'b10_0001_0000;
`endif
    @(posedge Clk); #1;
    A_Req = 1; A_Write = 0; A_Addr = 32'h10;
    B_Req = 1; B_Write = 0; B_Addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      got = 0;
      for (int j = 0; j < 20 && !got; j++) begin
        @(negedge Clk);
        if (A_Ready || B_Ready) got = 1;
      end
      check("t3_timeout", 32'(got), 32'd1);
      if (got) check($sformatf("t3_grant_%0d", i), 32'(B_Ready), 32'(exp_seq[i]));
    end
    @(posedge Clk); #1 A_Req = 0; B_Req = 0;

    // A drops its request in WAIT while B becomes pending
    @(posedge Clk); #1;
    A_Req = 1; A_Write = 0; A_Addr = 32'h10;
    @(posedge Clk); @(posedge Clk); #1;
    A_Req = 0; B_Req = 1; B_Write = 0; B_Addr = 32'h20;
    @(negedge Clk);
    check("t5_c2_ready", 32'(A_Ready), 32'd0);
    @(negedge Clk);
    check("t5_c3_ready", 32'(A_Ready), 32'd1);
    check("t5_c3_rdata", A_RData, 32'hDEAD_BEEF);
    check("t5_c3_stall", 32'(Stall_Pipe), 32'd0);
    @(negedge Clk);
    check("t5_c4_grant_b", 32'(Grant_B), 32'd0);
    @(negedge Clk);
    check("t5_c5_grant_b", 32'(Grant_B), 32'd1);
    check("t5_c5_read", 32'(Mem_Read), 32'd1);
    check("t5_c5_addr", Mem_Addr, 32'h20);
    wait_b_ready(rd);
    check("t5_b_rdata", rd, 32'h0000_1234);
    @(posedge Clk); #1 B_Req = 0;

    // asynchronous reset during the WAIT cycle of an A load
    @(posedge Clk); #1;
    A_Req = 1; A_Write = 0; A_Addr = 32'h10;
    @(posedge Clk); @(posedge Clk); #2;
    Rst = 1'b1; A_Req = 0;
    #1;
    check("t4_rst_read", 32'(Mem_Read), 32'd0);
    check("t4_rst_a_ready", 32'(A_Ready), 32'd0);
    check("t4_rst_stall", 32'(Stall_Pipe), 32'd0);
    check("t4_rst_grant_b", 32'(Grant_B), 32'd0);
    check("t4_rst_addr", Mem_Addr, 32'd0);
    check("t4_rst_a_rdata", A_RData, 32'd0);
    @(posedge Clk); #1 Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("t4_no_stale_ready", 32'(A_Ready), 32'd0);
    end
    a_load(32'h30, rd, lat);
    check("t4_new_rdata", rd, 32'hCAFE_F00D);
    check("t4_latency", 32'(lat), 32'(L + 1));

    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
